// File: rtl/uart_cmd_pkg.sv
// ============================================================================
//  Module   : uart_cmd_pkg
//  Brief    : Shared types/constants for the UART command frame parser.
//             Optional checksum stage enabled by UART_CMD_CSUM_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package uart_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPCODE  = 2'd1,
        PAYLOAD = 2'd2
`ifdef UART_CMD_CSUM_EN
        ,
        CSUM    = 2'd3
`endif
    } state_t;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [7:0] OP_DISP  = 8'h44;
    localparam logic [7:0] OP_LED   = 8'h4C;
    localparam logic [7:0] OP_CLR   = 8'h43;

    function automatic logic op_valid(input logic [7:0] op);
        return (op == OP_DISP) || (op == OP_LED) || (op == OP_CLR);
    endfunction

    function automatic logic [1:0] op_len(input logic [7:0] op);
        case (op)
            OP_DISP: return 2'd2;
            OP_LED:  return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_cmd_timeout.sv
// ============================================================================
//  Module   : uart_cmd_timeout
//  Brief    : Inter-byte timeout counter with clear, enable and expire pulse.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_cmd_timeout #(
    parameter int TIMEOUT_CLKS = 1250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CLKS - 1);

    logic [CW-1:0] r_cnt;

    assign expire = enable && (r_cnt == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= expire ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
// ============================================================================
//  Module   : uart_cmd_ctrl
//  Brief    : UART command frame parser driving display value and LEDs.
//             Define UART_CMD_CSUM_EN to require a trailing XOR checksum byte.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 1250000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [15:0] disp_val,
    output logic [3:0]  led,
    output logic        busy,
    output logic        frame_ok,
    output logic        frame_err
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_commit;
    logic        w_abort;
    logic        w_expire;
    logic        w_last;
    logic [7:0]  r_op;
    logic [1:0]  r_len;
    logic [1:0]  r_cnt;
    logic [7:0]  w_commit_op;
    logic [15:0] w_commit_data;

`ifdef UART_CMD_CSUM_EN
    logic [15:0] r_shadow;
    logic [15:0] w_shadow_nxt;
    logic [7:0]  r_csum;
    assign w_shadow_nxt  = {r_shadow[7:0], rx_data};
    assign w_commit_data = r_shadow;
`else
    // Commit happens on the last payload strobe, so that byte comes straight from rx_data.
    logic [7:0]  r_shadow;
    logic [7:0]  w_shadow_nxt;
    assign w_shadow_nxt  = rx_data;
    assign w_commit_data = {r_shadow, rx_data};
`endif

    assign w_last      = ((r_cnt + 2'd1) == r_len);
    assign w_commit_op = (r_state == OPCODE) ? rx_data : r_op;

    uart_cmd_timeout #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (rx_valid),
        .enable (r_state != IDLE),
        .expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_valid && (rx_data == HDR_BYTE)) w_state_nxt = OPCODE;
            end
            OPCODE: begin
                if (rx_valid) begin
                    if (!op_valid(rx_data)) begin
                        w_abort     = 1'b1;
                        w_state_nxt = IDLE;
                    end else if (op_len(rx_data) != 2'd0) begin
                        w_state_nxt = PAYLOAD;
                    end else begin
`ifdef UART_CMD_CSUM_EN
                        w_state_nxt = CSUM;
`else
                        w_commit    = 1'b1;
                        w_state_nxt = IDLE;
`endif
                    end
                end
            end
            PAYLOAD: begin
                if (rx_valid && w_last) begin
`ifdef UART_CMD_CSUM_EN
                    w_state_nxt = CSUM;
`else
                    w_commit    = 1'b1;
                    w_state_nxt = IDLE;
`endif
                end
            end
`ifdef UART_CMD_CSUM_EN
            CSUM: begin
                if (rx_valid) begin
                    w_commit    = (rx_data == r_csum);
                    w_abort     = (rx_data != r_csum);
                    w_state_nxt = IDLE;
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
        // A byte arriving in the expiry cycle takes priority over the timeout.
        if ((r_state != IDLE) && !rx_valid && w_expire) begin
            w_abort     = 1'b1;
            w_state_nxt = IDLE;
        end
    end

    always_comb begin
        busy = (r_state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_shadow  <= '0;
`ifdef UART_CMD_CSUM_EN
            r_csum    <= '0;
`endif
            disp_val  <= '0;
            led       <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_ok  <= w_commit;
            frame_err <= w_abort;
            if ((r_state == OPCODE) && rx_valid) begin
                r_op  <= rx_data;
                r_len <= op_len(rx_data);
                r_cnt <= 2'd0;
`ifdef UART_CMD_CSUM_EN
                r_csum <= rx_data;
`endif
            end
            if ((r_state == PAYLOAD) && rx_valid) begin
                r_shadow <= w_shadow_nxt;
                r_cnt    <= r_cnt + 2'd1;
`ifdef UART_CMD_CSUM_EN
                r_csum   <= r_csum ^ rx_data;
`endif
            end
            if (w_commit) begin
                case (w_commit_op)
                    OP_DISP: disp_val <= w_commit_data;
                    OP_LED:  led      <= w_commit_data[3:0];
                    OP_CLR: begin
                        disp_val <= '0;
                        led      <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
// ============================================================================
//  Module   : tb_uart_cmd_ctrl
//  Brief    : Scoreboard bench for uart_cmd_ctrl (works with or without
//             UART_CMD_CSUM_EN defined).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_cmd_ctrl;

    logic        clk;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [15:0] disp_val;
    logic [3:0]  led;
    logic        busy;
    logic        frame_ok;
    logic        frame_err;

    typedef struct packed {
        logic        ok;
        logic [15:0] disp;
        logic [3:0]  led;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          vectors;
    int          miscompares;
    logic [15:0] exp_disp;
    logic [3:0]  exp_led;

    uart_cmd_ctrl #(
        .TIMEOUT_CLKS (100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .disp_val  (disp_val),
        .led       (led),
        .busy      (busy),
        .frame_ok  (frame_ok),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at #1 after a rising edge; strobes are contiguous across calls.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] op, input int n,
                              input logic [7:0] p0, input logic [7:0] p1,
                              input logic [7:0] tweak);
        logic [7:0] cs;
        cs = op ^ tweak;
        send_byte(8'hA5);
        send_byte(op);
        if (n > 0) begin send_byte(p0); cs = cs ^ p0; end
        if (n > 1) begin send_byte(p1); cs = cs ^ p1; end
`ifdef UART_CMD_CSUM_EN
        send_byte(cs);
`endif
    endtask

    task automatic push(input logic ok);
        exp_t e;
        e.ok   = ok;
        e.disp = exp_disp;
        e.led  = exp_led;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && (frame_ok || frame_err)) begin
            check("ok_err_exclusive", {31'd0, frame_ok & frame_err}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", {30'd0, frame_ok, frame_err}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_kind", {31'd0, frame_ok}, {31'd0, mon_e.ok});
                check("disp_val", {16'd0, disp_val}, {16'd0, mon_e.disp});
                check("led", {28'd0, led}, {28'd0, mon_e.led});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_disp    = 16'h0000;
        exp_led     = 4'h0;
        rst_n       = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        idle(3);
        check("rst_disp", {16'd0, disp_val}, 32'd0);
        check("rst_led", {28'd0, led}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_flags", {30'd0, frame_ok, frame_err}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        exp_disp = 16'h1234; push(1'b1);
        send_frame(8'h44, 2, 8'h12, 8'h34, 8'h00);
        idle(2);
        check("busy_after_disp", {31'd0, busy}, 32'd0);
        check("led_untouched", {28'd0, led}, 32'd0);

`ifdef UART_CMD_CSUM_EN
        push(1'b0);
        send_frame(8'h44, 2, 8'h56, 8'h78, 8'h01);
`else
        exp_disp = 16'hABCD; push(1'b1);
        send_frame(8'h44, 2, 8'hAB, 8'hCD, 8'h00);
`endif
        idle(2);

        exp_led = 4'hB; push(1'b1);
        send_frame(8'h4C, 1, 8'h0B, 8'h00, 8'h00);
        exp_disp = 16'h0000; exp_led = 4'h0; push(1'b1);
        send_frame(8'h43, 0, 8'h00, 8'h00, 8'h00);
        idle(2);

        // Back-to-back frames with no gap.
        exp_disp = 16'h0001; push(1'b1);
        send_frame(8'h44, 2, 8'h00, 8'h01, 8'h00);
        exp_led = 4'hA; push(1'b1);
        send_frame(8'h4C, 1, 8'hFA, 8'h00, 8'h00);
        exp_disp = 16'hBEEF; push(1'b1);
        send_frame(8'h44, 2, 8'hBE, 8'hEF, 8'h00);
        idle(2);

        // Timeout after a partial frame.
        push(1'b0);
        send_byte(8'hA5); send_byte(8'h44); send_byte(8'h12);
        idle(99);
        check("timeout_not_yet", {31'd0, frame_err}, 32'd0);
        check("busy_before_to", {31'd0, busy}, 32'd1);
        idle(1);
        check("timeout_err", {31'd0, frame_err}, 32'd1);
        check("busy_after_to", {31'd0, busy}, 32'd0);
        exp_led = 4'h5; push(1'b1);
        send_frame(8'h4C, 1, 8'h05, 8'h00, 8'h00);
        idle(2);

        // Byte landing in the expiry cycle wins.
        exp_disp = 16'h1234; push(1'b1);
        send_byte(8'hA5); send_byte(8'h44);
        idle(99);
        check("busy_at_edge", {31'd0, busy}, 32'd1);
        send_byte(8'h12); send_byte(8'h34);
`ifdef UART_CMD_CSUM_EN
        send_byte(8'h62);
`endif
        idle(2);

        // Garbage in IDLE is ignored; header as opcode is an error.
        push(1'b0);
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5); send_byte(8'hA5);
        idle(2);
        check("busy_after_garbage", {31'd0, busy}, 32'd0);

        // Reset mid-frame.
        send_byte(8'hA5); send_byte(8'h44); send_byte(8'h12);
        rst_n = 1'b0;
        #1;
        check("midrst_disp", {16'd0, disp_val}, 32'd0);
        check("midrst_led", {28'd0, led}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        exp_disp = 16'h0000; exp_led = 4'h0;
        idle(3);
        rst_n = 1'b1;
        idle(120);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        exp_led = 4'h3; push(1'b1);
        send_frame(8'h4C, 1, 8'h03, 8'h00, 8'h00);
        idle(5);
        check("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CLKS, default 1250000; inter-byte timeout in clk cycles (50 ms at 25 MHz).
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-005 SHALL have port rx_data  input  8  received UART byte.
REQ-006 SHALL have port disp_val  output  16  display value, feeds the four svnseg_controller nibbles (num3=[15:12] .. num0=[3:0]).
REQ-007 SHALL have port led  output  4  LED pattern, 1 = lit.
REQ-008 SHALL have port busy  output  1  high while a frame is in progress (state != IDLE).
REQ-009 SHALL have port frame_ok  output  1  one-cycle pulse, frame applied.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse, frame discarded.

Function
REQ-011 SHALL parse frames: header 0xA5, opcode, payload, checksum (XOR of opcode and payload bytes).
REQ-012 SHALL support opcodes 0x44 'D' (2 payload bytes, high then low -> disp_val), 0x4C 'L' (1 byte, [3:0] -> led, [7:4] ignored), 0x43 'C' (0 bytes, clears disp_val and led).
REQ-013 SHALL use states IDLE, OPCODE, PAYLOAD, CSUM; transitions only on rx_valid, timeout or reset.
REQ-014 IDLE: 0xA5 -> OPCODE; any other byte ignored, no error.
REQ-015 OPCODE: valid opcode -> PAYLOAD (D, L) or CSUM (C); any other byte, including 0xA5 -> frame_err, IDLE.
REQ-016 PAYLOAD: shadow-buffer bytes; after last payload byte -> CSUM.
REQ-017 CSUM: match -> outputs updated and frame_ok pulsed on the cycle after the checksum strobe; mismatch -> frame_err, outputs unchanged; both -> IDLE.
REQ-018 disp_val and led SHALL change only on frame commit; a partial frame never alters them.
REQ-019 Timeout counter SHALL reset on every accepted rx_valid and count only outside IDLE; on reaching TIMEOUT_CLKS-1 -> frame_err, IDLE.
REQ-020 rx_valid and timeout in the same cycle: byte SHALL win, no error.
REQ-021 frame_ok and frame_err SHALL never assert together; each pulse lasts exactly one cycle.
REQ-022 Back-to-back frames with no idle cycles SHALL be accepted; the header may arrive on the cycle after the commit strobe.

Reset
REQ-023 rst_n low SHALL force IDLE immediately: disp_val=0, led=0, busy=0, frame_ok=0, frame_err=0, timer=0, shadow buffer=0.
REQ-024 Reset mid-frame SHALL discard the frame without a frame_err pulse.

Configuration
REQ-025 With UART_CMD_CSUM_EN defined: CSUM state and checksum byte as above.
REQ-026 Without UART_CMD_CSUM_EN: no checksum byte; commit occurs on the cycle after the last payload strobe (after the opcode strobe for 'C'); the CSUM state is absent.

Structure
REQ-027 Package uart_cmd_pkg SHALL hold the state enum, HDR_BYTE=8'hA5, OP_DISP, OP_LED and OP_CLR constants.
REQ-028 Sub-module uart_cmd_timeout SHALL implement the timeout counter (clear, enable, expire pulse), width $clog2(TIMEOUT_CLKS).

Verification
REQ-029 A5 44 12 34 62 -> disp_val=16'h1234, one frame_ok pulse, led unchanged.
REQ-030 A5 4C 0B 47 -> led=4'hB; then A5 43 43 -> disp_val=0, led=0.
REQ-031 A5 44 12 34 63 -> frame_err, disp_val keeps prior value.
REQ-032 A5 44 12, then silence for TIMEOUT_CLKS (set to 100) -> frame_err at cycle 100; then A5 4C 05 49 -> led=4'h5.
REQ-033 Bytes 00 FF A5 A5 -> no error for 00 FF; frame_err on the second A5; busy=0 afterwards.
REQ-034 Reset asserted after A5 44 12 -> all outputs 0, IDLE, no frame_err; build without UART_CMD_CSUM_EN: A5 44 AB CD -> disp_val=16'hABCD.
